display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 122 ++++++++++++
 tb/tb_display_scan_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Multiplexed 4-digit error display: scans digit enables, latches sensor error flags
// with bit-0 priority, blinks while an error is shown and handles operator acknowledge.
//
// state | meaning
// IDLE  | no error latched, display blank, waiting for a sensor flag
// SHOW  | error latched, digits scanned with blink, ack clears the latch
// HOLD  | acknowledged while the source is still active; wait for all flags low
module display_scan_ctrl #(
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_SLOTS = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] erro_sensor,
  input  logic       ack,
  output logic [1:0] digito,
  output logic [3:0] anodo,
  output logic [1:0] codigo,
  output logic       erro_ativo
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int SW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SLOT_MAX  = SW'(BLINK_SLOTS - 1);

  typedef enum logic [1:0] {IDLE, SHOW, HOLD} state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [SW-1:0] r_slot, w_slot_nxt;
  logic          r_blink, w_blink_nxt;
  logic [3:0]    r_latch, w_latch_nxt;
  logic [1:0]    r_digito, w_digito_nxt;
  logic [3:0]    r_anodo, w_anodo_nxt;
  logic [1:0]    r_codigo, w_codigo_nxt;
  logic          r_erro_ativo;
  logic          w_tc;

  always_comb begin
    w_tc         = (r_presc == PRESC_MAX);
    w_digito_nxt = w_tc ? r_digito + 2'd1 : r_digito;
    w_state_nxt  = r_state;
    w_latch_nxt  = r_latch;
    w_slot_nxt   = r_slot;
    w_blink_nxt  = r_blink;

    if (w_tc) begin
      if (r_slot == SLOT_MAX) begin
        w_slot_nxt  = '0;
        w_blink_nxt = ~r_blink;
      end else begin
        w_slot_nxt = r_slot + SW'(1);
      end
    end

    case (r_state)
      IDLE: begin
        w_latch_nxt = r_latch | erro_sensor;
        // Entering SHOW restarts the blink phase so the error is visible at once
        if (erro_sensor != 4'b0000) begin
          w_state_nxt = SHOW;
          w_blink_nxt = 1'b1;
          w_slot_nxt  = '0;
        end
      end
      SHOW: begin
        if (ack) begin
          w_latch_nxt = 4'b0000;
          w_state_nxt = ((erro_sensor & r_latch) != 4'b0000) ? HOLD : IDLE;
        end else begin
          w_latch_nxt = r_latch | erro_sensor;
        end
      end
      HOLD: begin
        if (erro_sensor == 4'b0000) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    casez (w_latch_nxt)
      4'b???1: w_codigo_nxt = 2'd0;
      4'b??10: w_codigo_nxt = 2'd1;
      4'b?100: w_codigo_nxt = 2'd2;
      4'b1000: w_codigo_nxt = 2'd3;
      default: w_codigo_nxt = 2'd0;
    endcase

    w_anodo_nxt = (w_state_nxt == SHOW && w_blink_nxt) ? ~(4'b0001 << w_digito_nxt) : 4'b1111;
  end

  // Outputs are registered from next-state values so they align with the state register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_latch      <= 4'b0000;
      r_presc      <= '0;
      r_slot       <= '0;
      r_blink      <= 1'b1;
      r_digito     <= 2'd0;
      r_codigo     <= 2'd0;
      r_erro_ativo <= 1'b0;
      r_anodo      <= 4'b1111;
    end else begin
      r_state      <= w_state_nxt;
      r_latch      <= w_latch_nxt;
      r_presc      <= w_tc ? '0 : r_presc + PW'(1);
      r_slot       <= w_slot_nxt;
      r_blink      <= w_blink_nxt;
      r_digito     <= w_digito_nxt;
      r_codigo     <= w_codigo_nxt;
      r_erro_ativo <= (w_state_nxt == SHOW);
      r_anodo      <= w_anodo_nxt;
    end
  end

  assign digito     = r_digito;
  assign anodo      = r_anodo;
  assign codigo     = r_codigo;
  assign erro_ativo = r_erro_ativo;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: cycle-level reference model plus directed vectors
// with hand-computed expectations (SCAN_DIV=4, BLINK_SLOTS=2).
module tb_display_scan_ctrl;
  localparam int SD = 4;
  localparam int BS = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] erro_sensor;
  logic       ack;
  logic [1:0] digito;
  logic [3:0] anodo;
  logic [1:0] codigo;
  logic       erro_ativo;

  int n_vec = 0;
  int n_err = 0;

  display_scan_ctrl #(.SCAN_DIV(SD), .BLINK_SLOTS(BS)) dut (
    .clock(clock), .reset(reset), .erro_sensor(erro_sensor), .ack(ack),
    .digito(digito), .anodo(anodo), .codigo(codigo), .erro_ativo(erro_ativo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] lowest(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) if (v[i]) r = 2'(i);
    return r;
  endfunction

  // Reference model: mode 0=idle 1=show 2=hold; cycles since reset and
  // terminal counts since entering show give digit and blink phase directly.
  int         m_mode, m_cyc, m_nent;
  logic [3:0] m_latch;
  bit         m_valid = 1'b0;
  bit         m_tc;

  always @(posedge clock) begin
    if (reset) begin
      m_mode = 0; m_latch = 4'h0; m_cyc = 0; m_nent = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_cyc++;
      m_tc = ((m_cyc % SD) == 0);
      case (m_mode)
        0: if (erro_sensor != 4'h0) begin
             m_mode = 1; m_latch = erro_sensor; m_nent = 0;
           end
        1: if (ack) begin
             m_mode  = ((erro_sensor & m_latch) != 4'h0) ? 2 : 0;
             m_latch = 4'h0;
           end else begin
             m_latch = m_latch | erro_sensor;
             if (m_tc) m_nent++;
           end
        2: if (erro_sensor == 4'h0) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
  end

  logic [1:0] e_dig;
  logic [3:0] e_an;
  bit         e_blink;

  always @(posedge clock) begin
    #2;
    if (m_valid) begin
      e_dig   = 2'((m_cyc / SD) % 4);
      e_blink = (((m_nent / BS) % 2) == 0);
      e_an    = (m_mode == 1 && e_blink) ? ~(4'b0001 << e_dig) : 4'hF;
      chk("m_digito", {2'b00, digito}, {2'b00, e_dig});
      chk("m_anodo", anodo, e_an);
      chk("m_codigo", {2'b00, codigo}, {2'b00, lowest(m_latch)});
      chk("m_erro_ativo", {3'b000, erro_ativo}, {3'b000, m_mode == 1});
    end
  end

  task automatic step(input logic [3:0] e, input logic a, input int n);
    erro_sensor = e;
    ack         = a;
    repeat (n) @(negedge clock);
  endtask

  int offc, onact;

  initial begin
    reset = 1'b1; erro_sensor = 4'h0; ack = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_anodo", anodo, 4'hF);
    chk("rst_ativo", {3'b000, erro_ativo}, 4'h0);
    chk("rst_codigo", {2'b00, codigo}, 4'h0);
    chk("rst_digito", {2'b00, digito}, 4'h0);
    reset = 1'b0;

    step(4'h0, 1'b0, 4);  chk("scan_d1", {2'b00, digito}, 4'h1);
    step(4'h0, 1'b0, 4);  chk("scan_d2", {2'b00, digito}, 4'h2);
    step(4'h0, 1'b0, 4);  chk("scan_d3", {2'b00, digito}, 4'h3);
    step(4'h0, 1'b0, 4);  chk("scan_d0", {2'b00, digito}, 4'h0);
    chk("idle_anodo", anodo, 4'hF);

    step(4'b0100, 1'b0, 1);
    chk("err2_ativo", {3'b000, erro_ativo}, 4'h1);
    chk("err2_codigo", {2'b00, codigo}, 4'h2);
    step(4'h0, 1'b0, 3);
    chk("err2_held", {2'b00, codigo}, 4'h2);
    step(4'b0010, 1'b0, 1); chk("err1_codigo", {2'b00, codigo}, 4'h1);
    step(4'b0001, 1'b0, 1); chk("err0_codigo", {2'b00, codigo}, 4'h0);

    erro_sensor = 4'h0;
    offc = 0; onact = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (anodo == 4'hF) offc++;
      if (erro_ativo) onact++;
    end
    chk("blink_off_cycles", 4'(offc), 4'd8);
    chk("blink_ativo_cycles", 5'(onact) == 5'd16 ? 4'h1 : 4'h0, 4'h1);

    step(4'b0010, 1'b1, 1);
    chk("hold_ativo", {3'b000, erro_ativo}, 4'h0);
    chk("hold_anodo", anodo, 4'hF);
    step(4'b0010, 1'b0, 5);
    chk("hold_stays", {3'b000, erro_ativo}, 4'h0);
    step(4'h0, 1'b0, 1);
    step(4'b1000, 1'b0, 1);
    chk("after_hold_ativo", {3'b000, erro_ativo}, 4'h1);
    chk("after_hold_codigo", {2'b00, codigo}, 4'h3);

    step(4'h0, 1'b1, 1);
    chk("ack_idle_ativo", {3'b000, erro_ativo}, 4'h0);
    chk("ack_idle_codigo", {2'b00, codigo}, 4'h0);
    step(4'h0, 1'b1, 3);
    chk("ack_in_idle", {3'b000, erro_ativo}, 4'h0);
    step(4'b0001, 1'b1, 1);
    chk("idle_ignores_ack", {3'b000, erro_ativo}, 4'h1);
    step(4'b0001, 1'b1, 1);
    chk("ack_to_hold", {3'b000, erro_ativo}, 4'h0);
    step(4'h0, 1'b0, 2);

    step(4'b0100, 1'b0, 1);
    step(4'b0010, 1'b1, 1);
    chk("ack_wins_new_bit", {3'b000, erro_ativo}, 4'h0);
    step(4'h0, 1'b0, 2);

    step(4'b0001, 1'b0, 3);
    reset = 1'b1;
    step(4'b0001, 1'b1, 1);
    chk("mid_rst_ativo", {3'b000, erro_ativo}, 4'h0);
    chk("mid_rst_anodo", anodo, 4'hF);
    chk("mid_rst_codigo", {2'b00, codigo}, 4'h0);
    chk("mid_rst_digito", {2'b00, digito}, 4'h0);
    reset = 1'b0;
    step(4'b0001, 1'b0, 1);
    chk("relatch_ativo", {3'b000, erro_ativo}, 4'h1);
    chk("relatch_codigo", {2'b00, codigo}, 4'h0);
    step(4'h0, 1'b0, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
